// File: rtl/addition_stage2_aligner.sv
// addition_stage2_aligner: iterative right-aligner for the smaller FP adder operand
// Shifts {hidden,mantissa,G,R,S} one bit per cycle with sticky accumulation and a saturation fast-path.
module addition_stage2_aligner #(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    parameter int ALGN_WIDTH = MENT_WIDTH + 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [EXPO_WIDTH:0]   exp_diff_in,
    input  logic [MENT_WIDTH-1:0] smaller_operand_in,
    input  logic                  smaller_hidden_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [ALGN_WIDTH-1:0] aligned_operand_out,
    output logic                  swap_out
);
    localparam int CW = $clog2(ALGN_WIDTH);
    localparam logic [EXPO_WIDTH:0] ALGN_MAG = (EXPO_WIDTH + 1)'(ALGN_WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state, state_nx;
    logic [ALGN_WIDTH-1:0] sr, sr_nx;
    logic [CW-1:0]         count, count_nx;
    logic                  swap_nx;
    logic [EXPO_WIDTH:0]   mag;
    // -256 negates to itself and reads as unsigned 256, which saturates
    assign mag = exp_diff_in[EXPO_WIDTH] ? -exp_diff_in : exp_diff_in;
    assign ready_out = (state == IDLE);
    assign valid_out = (state == DONE);
    assign aligned_operand_out = sr;
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        count_nx = count;
        swap_nx  = swap_out;
        case (state)
            IDLE: if (valid_in) begin
                sr_nx   = {smaller_hidden_in, smaller_operand_in, 3'b000};
                swap_nx = exp_diff_in[EXPO_WIDTH];
                if (mag == '0) begin
                    state_nx = DONE;
                end else if (mag < ALGN_MAG) begin
                    count_nx = mag[CW-1:0];
                    state_nx = SHIFT;
                end else begin
                    sr_nx    = {{(ALGN_WIDTH-1){1'b0}}, |{smaller_hidden_in, smaller_operand_in}};
                    state_nx = DONE;
                end
            end
            SHIFT: begin
                sr_nx    = {1'b0, sr[ALGN_WIDTH-1:2], sr[1] | sr[0]};
                count_nx = count - CW'(1);
                state_nx = (count == CW'(1)) ? DONE : SHIFT;
            end
            DONE: state_nx = ready_in ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            sr       <= '0;
            count    <= '0;
            swap_out <= 1'b0;
        end else begin
            state    <= state_nx;
            sr       <= sr_nx;
            count    <= count_nx;
            swap_out <= swap_nx;
        end
    end
endmodule

// File: tb/tb_addition_stage2_aligner.sv
// tb_addition_stage2_aligner: directed checks of alignment, latency, sticky, saturation, backpressure, reset
module tb_addition_stage2_aligner;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [8:0]  exp_diff_in = '0;
    logic [22:0] smaller_operand_in = '0;
    logic        smaller_hidden_in = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [26:0] aligned_operand_out;
    logic        swap_out;
    int          tests = 0;
    int          failed = 0;
    int          lat;
    logic [26:0] held;
    logic        rose;

    addition_stage2_aligner dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .exp_diff_in(exp_diff_in), .smaller_operand_in(smaller_operand_in),
        .smaller_hidden_in(smaller_hidden_in), .valid_out(valid_out), .ready_in(ready_in),
        .aligned_operand_out(aligned_operand_out), .swap_out(swap_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operand at the next edge and measure edges until valid_out.
    task automatic accept(input logic [8:0] d, input logic h, input logic [22:0] m);
        @(negedge clk_in);
        valid_in = 1'b1;
        exp_diff_in = d;
        smaller_hidden_in = h;
        smaller_operand_in = m;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 40) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [8:0] d, input logic h, input logic [22:0] m,
                          input int exp_lat, input logic [26:0] exp_out, input logic exp_swap);
        accept(d, h, m);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " out"}, aligned_operand_out, exp_out);
        check({tag, " swap"}, swap_out, exp_swap);
        @(posedge clk_in);
        #1;
        check({tag, " ready after"}, ready_out, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        check("reset ready", ready_out, 1'b1);
        check("reset valid", valid_out, 1'b0);
        check("reset out", aligned_operand_out, 27'h0);
        check("reset swap", swap_out, 1'b0);
        rst_in = 1'b0;
        run_op("T1 diff0", 9'h000, 1'b1, 23'h0, 1, 27'h4000000, 1'b0);
        run_op("T2 diff3", 9'h003, 1'b1, 23'h0, 4, 27'h0800000, 1'b0);
        run_op("T3 sticky", 9'h005, 1'b1, 23'h000001, 6, 27'h0200001, 1'b0);
        run_op("T4 neg2", 9'h1FE, 1'b1, 23'h0, 3, 27'h1000000, 1'b1);
        run_op("T5 sat30", 9'h01E, 1'b1, 23'h0, 1, 27'h0000001, 1'b0);
        run_op("T5 sat zero", 9'h01E, 1'b0, 23'h0, 1, 27'h0, 1'b0);
        run_op("diff26", 9'h01A, 1'b1, 23'h0, 27, 27'h0000001, 1'b0);
        run_op("diff27 sat", 9'h01B, 1'b0, 23'h400000, 1, 27'h0000001, 1'b0);
        run_op("neg256 sat", 9'h100, 1'b1, 23'h7FFFFF, 1, 27'h0000001, 1'b1);
        run_op("zero shift8", 9'h008, 1'b0, 23'h0, 9, 27'h0, 1'b0);
        run_op("mant shift1", 9'h001, 1'b1, 23'h7FFFFF, 2, 27'h3FFFFFC, 1'b0);
        // backpressure: result and valid held, new valid_in ignored while in DONE
        ready_in = 1'b0;
        accept(9'h003, 1'b1, 23'h0);
        check("T6 latency", lat, 4);
        valid_in = 1'b1;
        exp_diff_in = 9'h000;
        smaller_hidden_in = 1'b0;
        smaller_operand_in = 23'h123456;
        held = aligned_operand_out;
        repeat (5) @(posedge clk_in);
        #1;
        check("T6 valid held", valid_out, 1'b1);
        check("T6 ready low", ready_out, 1'b0);
        check("T6 out held", aligned_operand_out, 27'h0800000);
        check("T6 out stable", aligned_operand_out, held);
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("T6 release ready", ready_out, 1'b1);
        check("T6 release valid", valid_out, 1'b0);
        // reset in the middle of a shift discards the operation
        @(negedge clk_in);
        valid_in = 1'b1;
        exp_diff_in = 9'h1F6;
        smaller_hidden_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        check("T6 shifting", ready_out, 1'b0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("T6 rst ready", ready_out, 1'b1);
        check("T6 rst swap", swap_out, 1'b0);
        check("T6 rst out", aligned_operand_out, 27'h0);
        rose = 1'b0;
        repeat (15) begin
            @(posedge clk_in);
            #1;
            rose = rose | valid_out;
        end
        check("T6 no valid after rst", rose, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
